fp_min_sum_tracker: RTL
=======================

// Module: fp_min_sum_tracker
// PURPOSE
// Streaming min-sum check-node front end for the belief-propagation decoder. Accepts the
// DEG floating-point messages of one check row serially. Tracks the smallest magnitude
// (min1), the second-smallest magnitude (min2), the index of min1, and the XOR of all sign
// bits. Returns the row result over a valid/ready handshake. Extends the combinational
// float less-than compare into a parametrised, sequential multi-input tracker.
// PARAMETERS
// EXP_W    8    exponent width; word width W = 1+EXP_W+MAN_W (default IEEE-754 single)
// MAN_W    23   mantissa width
// DEG_MAX  16   max row degree accepted per start
// IDX_W    $clog2(DEG_MAX)   index width (derived, not overridden)
// PORTS
// clk       in   1         rising-edge clock
// rst       in   1         asynchronous active-high reset
// start     in   1         begin a row; sampled only in IDLE
// deg       in   IDX_W+1   row degree, sampled with start; legal 1..DEG_MAX
// in_valid  in   1         in_data valid
// in_ready  out  1         tracker accepts in_data this cycle
// in_data   in   W         message {sign,exp,man}
// out_valid out  1         row result valid
// out_ready in   1         downstream accepts result
// min1      out  W         smallest magnitude, sign bit forced 0
// min2      out  W         second-smallest magnitude, sign bit forced 0
// min1_idx  out  IDX_W     position (0-based, arrival order) of min1
// sign_xor  out  1         XOR of all accepted sign bits
// busy      out  1         high in ACCUM or HOLD
// BEHAVIOUR
// - Reset (async, any state): state=IDLE. in_ready, out_valid, busy, min1, min2,
//   min1_idx and sign_xor all 0. Element counter 0.
// - FSM IDLE -> ACCUM: start=1 and 1<=deg<=DEG_MAX. Latch deg, clear counter.
//   start with deg=0 or deg>DEG_MAX: ignored, stay IDLE.
// - ACCUM: in_ready=1. Element accepted when in_valid&in_ready, at most 1 per cycle.
//   in_valid gaps are allowed. start is ignored.
// - Magnitude compare: unsigned compare of {exp,man} (W-1 bits). This is correct for
//   normals, denormals and +/-0 (equal). NaN is unsupported and orders as a large value.
// - Element 0: min1=|x|, min1_idx=0, min2=+inf ({0,all-ones exp,0}), sign_xor=sign.
// - Element k>0: sign_xor ^= sign.
//   - If |x| < min1 (strict): min2<=min1, min1<=|x|, min1_idx<=k.
//   - Else if |x| < min2: min2<=|x|.
//   - Ties: the earliest index stays min1. An equal value moves into min2.
// - ACCUM -> HOLD: on the cycle the deg-th element is accepted. in_ready drops next cycle.
//   out_valid=1 the cycle after the last accept (latency 1 clock).
// - HOLD: out_valid=1. min1, min2, min1_idx and sign_xor are stable until the handshake.
//   in_ready=0. start is ignored.
// - HOLD -> IDLE: when out_valid&out_ready. out_valid=0 next cycle.
//   Result registers keep their values until the next row's element 0.
// - deg=1: out_valid=1 with min2=+inf.
// - Reset mid-ACCUM/HOLD: partial row discarded. The next start begins a fresh row.
// TESTING
// 1 deg=3 {3F99999A(1.2),3E99999A(0.3),42C80000(100)} -> min1=3E99999A min2=3F99999A
//   idx=1 sign_xor=0; out_valid exactly 1 clk after 3rd accept
// 2 deg=4 {C0200000(-2.5),3F99999A,3E99999A,42C80000} -> min1=3E99999A min2=3F99999A
//   idx=2 sign_xor=1
// 3 deg=3 {42C80000 x3} -> min1=min2=42C80000 idx=0 sign_xor=0; also {80000000,00000000}
//   deg=2 -> min1=min2=0 idx=0 sign_xor=1
// 4 deg=1 {BF99999A(-1.2)} -> min1=3F99999A min2=7F800000 idx=0 sign_xor=1
// 5 in_valid toggled 1-0-1 in ACCUM, out_ready held 0 for 5 clks in HOLD -> result identical
//   to gap-free run; outputs stable, in_ready=0 throughout HOLD; start pulses ignored
// 6 rst pulsed after 2 of 4 elements -> all outputs 0 asynchronously; then deg=2
//   {42C80000,3F99999A} -> min1=3F99999A min2=42C80000 idx=1

Source files
------------

// File: rtl/fp_min_sum_tracker.sv
// rtl/fp_min_sum_tracker.sv - serial min-sum check-node tracker (min1, min2, min1 index, sign XOR)
// Takes one check row of floating-point messages, one per handshake, and returns the row summary.
module fp_min_sum_tracker #(
    parameter  int EXP_W   = 8,
    parameter  int MAN_W   = 23,
    parameter  int DEG_MAX = 16,
    localparam int W       = 1 + EXP_W + MAN_W,
    localparam int IDX_W   = (DEG_MAX > 1) ? $clog2(DEG_MAX) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDX_W:0]   deg,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     min1,
    output logic [W-1:0]     min2,
    output logic [IDX_W-1:0] min1_idx,
    output logic             sign_xor,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_ACCUM = 2'b01;
    localparam logic [1:0] S_HOLD  = 2'b10;

    localparam logic [IDX_W:0] DEG_LIMIT = (IDX_W + 1)'(DEG_MAX);
    localparam logic [W-1:0]   POS_INF   = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   deg_q, deg_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [W-1:0]     min1_q, min1_d;
    logic [W-1:0]     min2_q, min2_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             sxor_q, sxor_d;

    logic             deg_ok;
    logic             accept;
    logic [IDX_W:0]   cnt_inc;
    logic [W-2:0]     in_mag;
    logic             in_sign;
    logic             lt_min1;
    logic             lt_min2;

    // Magnitude order is the unsigned order of {exp,man}; holds for normals, denormals and zeros.
    assign in_mag   = in_data[W-2:0];
    assign in_sign  = in_data[W-1];
    assign lt_min1  = in_mag < min1_q[W-2:0];
    assign lt_min2  = in_mag < min2_q[W-2:0];
    assign deg_ok   = (deg != '0) && (deg <= DEG_LIMIT);
    assign accept   = (state_q == S_ACCUM) && in_valid;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        deg_d   = deg_q;
        cnt_d   = cnt_q;
        min1_d  = min1_q;
        min2_d  = min2_q;
        idx_d   = idx_q;
        sxor_d  = sxor_q;
        case (state_q)
            S_IDLE: begin
                if (start && deg_ok) begin
                    state_d = S_ACCUM;
                    deg_d   = deg;
                    cnt_d   = '0;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == '0) begin
                        min1_d = {1'b0, in_mag};
                        min2_d = POS_INF;
                        idx_d  = '0;
                        sxor_d = in_sign;
                    end else begin
                        sxor_d = sxor_q ^ in_sign;
                        // Strict compare keeps the earliest index as min1 on ties.
                        if (lt_min1) begin
                            min2_d = min1_q;
                            min1_d = {1'b0, in_mag};
                            idx_d  = cnt_q[IDX_W-1:0];
                        end else if (lt_min2) begin
                            min2_d = {1'b0, in_mag};
                        end
                    end
                    if (cnt_inc == deg_q) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            deg_q   <= '0;
            cnt_q   <= '0;
            min1_q  <= '0;
            min2_q  <= '0;
            idx_q   <= '0;
            sxor_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            deg_q   <= deg_d;
            cnt_q   <= cnt_d;
            min1_q  <= min1_d;
            min2_q  <= min2_d;
            idx_q   <= idx_d;
            sxor_q  <= sxor_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_HOLD);
    assign busy      = (state_q == S_ACCUM) || (state_q == S_HOLD);
    assign min1      = min1_q;
    assign min2      = min2_q;
    assign min1_idx  = idx_q;
    assign sign_xor  = sxor_q;

endmodule
